// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frame-level controller behind the UART receiver.
// Assembles HEADER, ADDR, DATA, CHK byte frames into register-write strobes,
// flags checksum errors and inter-byte timeouts, and counts good frames.
`timescale 1ns / 1ps

module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER      = 8'h55,
    parameter int unsigned TIMEOUT_CYC = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StChk} state_e;

    // Counter value at which the frame is declared stalled.
    localparam logic [23:0] TmoLast = 24'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        rx_done_q;
    logic        byte_evt;
    logic        timeout;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  chk_sum;
    logic [23:0] tmo_q, tmo_d;
    logic        wr_en_d, frame_err_d, busy_d;
    logic [7:0]  wr_addr_d, wr_data_d, frame_cnt_d;

    // A long rx_done level counts once; the 1 reset value hides a level
    // that is already high when reset is released.
    assign byte_evt = rx_done & ~rx_done_q;
    assign chk_sum  = addr_q + data_q;
    // A byte arriving in the timeout cycle takes priority.
    assign timeout  = (state_q != StIdle) && (tmo_q == TmoLast) && !byte_evt;

    // Previous-cycle copy of rx_done for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b1;
        end else begin
            rx_done_q <= rx_done;
        end
    end

    // Frame state, holding registers, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            tmo_q     <= 24'd0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            frame_cnt <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            wr_en     <= wr_en_d;
            frame_err <= frame_err_d;
            busy      <= busy_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            frame_cnt <= frame_cnt_d;
        end
    end

    // Next-state and output decode on byte events and timeouts.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tmo_d       = tmo_q + 24'd1;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        frame_cnt_d = frame_cnt;

        if (state_q == StIdle || byte_evt) begin
            tmo_d = 24'd0;
        end

        if (byte_evt) begin
            case (state_q)
                StIdle: begin
                    // Non-header bytes between frames are dropped silently.
                    if (rx_data == HEADER) begin
                        state_d = StAddr;
                    end
                end
                StAddr: begin
                    addr_d  = rx_data;
                    state_d = StData;
                end
                StData: begin
                    data_d  = rx_data;
                    state_d = StChk;
                end
                StChk: begin
                    state_d = StIdle;
                    if (rx_data == chk_sum) begin
                        wr_en_d     = 1'b1;
                        wr_addr_d   = addr_q;
                        wr_data_d   = data_q;
                        frame_cnt_d = frame_cnt + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            tmo_d       = 24'd0;
        end

        busy_d = (state_d != StIdle);
    end

endmodule
